// File: rtl/bcd_serial_adder_ctrl.sv
// Multi-digit BCD adder sequencer: one shared single-digit decimal add stage,
// stepped across DIGITS positions LSD first, with start/busy/done handshake.
module bcd_serial_adder_ctrl #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  err
);

  localparam int unsigned IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state_q;
  logic [4*DIGITS-1:0] a_q, b_q, sum_q;
  logic [IDXW-1:0]     idx_q;
  logic                carry_q, cout_q, err_q, busy_q, done_q;

  logic [3:0]          a_dig, b_dig, sum_dig;
  logic [4:0]          t;
  logic                digit_bad, carry_d;
  logic [4*DIGITS-1:0] sum_d;

  // Select the current digit pair and splice the new sum digit into place.
  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (idx_q == IDXW'(k)) begin
        a_dig = a_q[4*k +: 4];
        b_dig = b_q[4*k +: 4];
      end
    end

    digit_bad = (a_dig > 4'd9) || (b_dig > 4'd9);
    t         = {1'b0, a_dig} + {1'b0, b_dig} + {4'd0, carry_q};

    if (digit_bad) begin
      sum_dig = 4'hF;
      carry_d = 1'b0;
    end else if (t > 5'd9) begin
      sum_dig = 4'(t - 5'd10);
      carry_d = 1'b1;
    end else begin
      sum_dig = t[3:0];
      carry_d = 1'b0;
    end

    sum_d = sum_q;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (idx_q == IDXW'(k)) sum_d[4*k +: 4] = sum_dig;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_ADD;
          end
        end
        ST_ADD: begin
          sum_q   <= sum_d;
          carry_q <= carry_d;
          err_q   <= err_q | digit_bad;
          idx_q   <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            cout_q  <= carry_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign err  = err_q;

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Bench for bcd_serial_adder_ctrl: decimal-arithmetic reference model with a
// per-cycle output compare, directed literal cases and randomized traffic.
module tb_bcd_serial_adder_ctrl;

  localparam int D = 4;
  localparam int W = 4 * D;

  logic         clk = 1'b0;
  logic         reset, start, cin;
  logic [W-1:0] a, b;
  logic         busy, done, cout, err;
  logic [W-1:0] sum;

  always #5 clk = ~clk;

  bcd_serial_adder_ctrl #(.DIGITS(D)) dut (
    .CLOCK_50(clk), .reset(reset), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .err(err)
  );

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         e;
  } res_t;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Valid operands: ordinary decimal integer addition. Any bad digit: that
  // position yields F and breaks the carry chain, others add normally.
  function automatic res_t ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    res_t   r;
    bit     ok = 1'b1;
    longint va = 0, vb = 0, p = 1, tot, rem;
    int     c;
    r = '0;
    for (int k = 0; k < D; k++)
      if (x[4*k +: 4] > 9 || y[4*k +: 4] > 9) ok = 1'b0;
    if (ok) begin
      for (int k = 0; k < D; k++) begin
        va += longint'(x[4*k +: 4]) * p;
        vb += longint'(y[4*k +: 4]) * p;
        p  *= 10;
      end
      tot = va + vb + longint'(ci);
      r.c = (tot >= p);
      rem = tot % p;
      for (int k = 0; k < D; k++) begin
        r.s[4*k +: 4] = 4'(rem % 10);
        rem /= 10;
      end
    end else begin
      c = int'(ci);
      r.e = 1'b1;
      for (int k = 0; k < D; k++) begin
        int da = int'(x[4*k +: 4]);
        int db = int'(y[4*k +: 4]);
        if (da > 9 || db > 9) begin
          r.s[4*k +: 4] = 4'hF;
          c = 0;
        end else begin
          r.s[4*k +: 4] = 4'((da + db + c) % 10);
          c = (da + db + c) / 10;
        end
      end
      r.c = c[0];
    end
    return r;
  endfunction

  // Model timeline: ph=0 idle, 1..D busy cycles, D+1 the done cycle.
  int           ph = 0;
  res_t         pend;
  logic [W-1:0] exp_sum = '0;
  logic         exp_cout = 1'b0, exp_err = 1'b0;
  int           exp_dones = 0, dut_dones = 0;

  always @(posedge clk) begin
    if (reset) begin
      ph = 0; exp_sum = '0; exp_cout = 1'b0; exp_err = 1'b0;
    end else if (ph == 0) begin
      if (start) begin
        pend = ref_add(a, b, cin);
        exp_sum = '0; exp_cout = 1'b0; exp_err = 1'b0;
        ph = 1;
      end
    end else if (ph <= D) begin
      ph++;
      if (ph == D + 1) begin
        exp_sum = pend.s; exp_cout = pend.c; exp_err = pend.e;
        exp_dones++;
      end
    end else begin
      ph = 0;
    end
  end

  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(ph >= 1 && ph <= D));
    chk("done", 32'(done), 32'(ph == D + 1));
    if (ph == 0 || ph == D + 1) begin
      chk("sum", 32'(sum), 32'(exp_sum));
      chk("cout", 32'(cout), 32'(exp_cout));
      chk("err", 32'(err), 32'(exp_err));
    end
    if (done) dut_dones++;
  end

  task automatic wait_done(input string nm, output int nbusy);
    bit got = 1'b0;
    nbusy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin got = 1'b1; break; end
      if (busy) nbusy++;
    end
    chk({nm, "_done_seen"}, 32'(got), 32'd1);
  endtask

  task automatic do_op(input string nm, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic ci, input logic [W-1:0] es, input logic ec, input logic ee);
    int nb;
    @(posedge clk); #1;
    a = x; b = y; cin = ci; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(nm, nb);
    chk({nm, "_sum"}, 32'(sum), 32'(es));
    chk({nm, "_cout"}, 32'(cout), 32'(ec));
    chk({nm, "_err"}, 32'(err), 32'(ee));
    chk({nm, "_busy_cycles"}, 32'(nb), 32'(D));
  endtask

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] v;
    for (int k = 0; k < D; k++)
      v[4*k +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                 : 4'($urandom_range(0, 9));
    return v;
  endfunction

  initial begin
    res_t r;
    int   base, nb;

    reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;

    r = ref_add(16'h1234, 16'h5678, 1'b0);
    chk("pin_ref_6912", 32'({r.s, r.c, r.e}), 32'({16'h6912, 1'b0, 1'b0}));
    r = ref_add(16'h12A4, 16'h0001, 1'b0);
    chk("pin_ref_12F5", 32'({r.s, r.c, r.e}), 32'({16'h12F5, 1'b0, 1'b1}));

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_sum", 32'(sum), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);

    do_op("add1234", 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0);
    do_op("ripple", 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op("max19", 16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0);
    do_op("invalid", 16'h12A4, 16'h0001, 1'b0, 16'h12F5, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    chk("err_sticky", 32'(err), 32'd1);
    do_op("after_err", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

    // start re-pulsed and operands changed during ADD
    @(posedge clk); #1;
    a = 16'h4321; b = 16'h1111; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    base = dut_dones;
    @(posedge clk); #1;
    start = 1'b1; a = 16'($urandom); b = 16'($urandom); cin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("midop", nb);
    chk("midop_sum", 32'(sum), 32'h5433);
    chk("midop_cout", 32'(cout), 32'd0);
    repeat (6) @(negedge clk);
    chk("midop_one_done", 32'(dut_dones - base), 32'd1);

    // reset during the third ADD cycle
    @(posedge clk); #1;
    a = 16'h5555; b = 16'h4444; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    base = dut_dones;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    repeat (6) @(negedge clk);
    chk("rst_no_done", 32'(dut_dones - base), 32'd0);
    do_op("post_rst", 16'h0500, 16'h0600, 1'b0, 16'h1100, 1'b0, 1'b0);

    repeat (1500) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 3) != 0);
      a     = rand_bcd();
      b     = rand_bcd();
      cin   = 1'($urandom_range(0, 1));
      reset = ($urandom_range(0, 199) == 0);
    end
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("done_count", 32'(dut_dones), 32'(exp_dones));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_serial_adder_ctrl.md
# bcd_serial_adder_ctrl

Sequencer for multi-digit BCD addition. It time-shares one single-digit BCD add stage (4-bit + 4-bit + carry with decimal correction) across DIGITS digit positions, least significant digit first, and handles the carry chain, invalid-digit detection and a start/busy/done handshake. It sits between the switch/operand registers and the 7-segment decoders of the multi-digit adder top level, so digit count is no longer bounded by combinational width.

## Interface
- DIGITS, 4, number of BCD digits per operand (≥1)
- CLOCK_50  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- a  in  4*DIGITS  operand A; digit k = bits 4k+3..4k
- b  in  4*DIGITS  operand B, same packing
- cin  in  1  carry into digit 0
- busy  out  1  high while an addition is in progress (ADD state)
- done  out  1  one-cycle pulse when sum/cout/err are valid
- sum  out  4*DIGITS  BCD result, same packing
- cout  out  1  decimal carry out of the top digit
- err  out  1  sticky: some operand digit was >9 in the last operation

## Operation
- FSM states: IDLE, ADD, DONE.
- IDLE: busy=0. On an edge with start=1:
  - latch a, b;
  - load the carry register with cin;
  - set digit index idx=0;
  - clear sum, cout and err;
  - go to ADD.
- ADD: each edge processes digit idx of the latched operands:
  - t = a_d + b_d + carry, as a 5-bit value (0..19).
  - If both digits are ≤9: if t>9, sum digit = t−10 and carry=1; else sum digit = t and carry=0.
  - If either digit is >9: sum digit = 4'hF, carry=0, err=1. Processing continues with the next digit.
  - idx increments. At idx=DIGITS−1 the edge also writes cout=carry_next and goes to DONE.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- sum, cout and err hold their values after DONE until the next accepted start.
- start in ADD or DONE is ignored and is not queued.
- Operands are latched, so changes on a/b/cin after acceptance do not affect the result.
- idx width is clog2(DIGITS), minimum 1. idx resets to 0 on each accepted start.

## Timing
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, err=0, carry=0, idx=0.
- Reset asserted mid-operation: on the next edge the block returns to IDLE with all outputs at reset values. No done pulse is produced.
- Reset has priority over start on the same edge.
- Latency: start accepted at edge E0 → busy high from E0 to E0+DIGITS → done high in the cycle following edge E0+DIGITS.
- Total: DIGITS+1 cycles from acceptance to IDLE.
- Back-to-back: start may be held high. It is accepted again on the first edge in IDLE, which is the edge after done, so throughput is one result per DIGITS+2 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.
- DIGITS=1: a single ADD cycle, then DONE.

## Test plan
- DIGITS=4, a=0x1234, b=0x5678, cin=0, start pulse → 5 cycles later done=1, sum=0x6912, cout=0, err=0; busy high exactly 4 cycles.
- a=0x9999, b=0x0001, cin=0 → sum=0x0000, cout=1, err=0. This checks ripple of the carry through all digits.
- a=0x9999, b=0x9999, cin=1 → sum=0x9999, cout=1. This is the maximum t=19 case on every digit.
- a=0x12A4, b=0x0001 → sum=0x12F5, cout=0, err=1. err stays 1 until the next start; a following valid add of 0x0001+0x0001 gives sum=0x0002, err=0.
- Pulse start again at the 2nd ADD cycle, and change a/b mid-operation → result matches the originally latched operands and there is exactly one done pulse.
- Assert reset in the 3rd ADD cycle → next cycle: busy=0, done=0, sum=0, cout=0, err=0; no done pulse. A subsequent start completes normally.
